// File: rtl/pc_unit.sv
// Program-counter unit for the Otter fetch stage: reset vector, boot hold,
// prioritised next-PC selection, misaligned-redirect trapping and halt/resume.
module pc_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int unsigned     IALIGN      = 4,
    parameter int unsigned     BOOT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic            redir,
    input  logic [XLEN-1:0] redir_tgt,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic [XLEN-1:0] pc_prev,
    output logic            pc_valid,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr
);

    localparam int unsigned     CW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [XLEN-1:0] LOW_MASK  = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] STEP      = XLEN'(IALIGN);
    localparam logic [CW-1:0]   BOOT_LAST = CW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   boot_cnt;
    logic            redir_aligned;
    logic [XLEN-1:0] trap_pc;

    assign pc_plus       = pc + STEP;
    assign redir_aligned = (redir_tgt & LOW_MASK) == '0;
    assign trap_pc       = trap_vec & ~LOW_MASK;

    // Status flags are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BOOT;
            boot_cnt <= BOOT_LAST;
            pc       <= RESET_VEC;
            pc_prev  <= RESET_VEC;
            bad_addr <= '0;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                ST_BOOT: begin
                    if (boot_cnt == '0) begin
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt - CW'(1);
                    end
                end
                ST_RUN: begin
                    if (trap) begin
                        pc      <= trap_pc;
                        pc_prev <= pc;
                    end else if (redir) begin
                        // A bad target blocks the whole update, including a same-cycle advance.
                        if (redir_aligned) begin
                            pc      <= redir_tgt;
                            pc_prev <= pc;
                        end else begin
                            misalign <= 1'b1;
                            bad_addr <= redir_tgt;
                        end
                    end else if (adv) begin
                        pc      <= pc_plus;
                        pc_prev <= pc;
                    end
                    if (halt_req) begin
                        state    <= ST_HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (trap || resume) begin
                        if (trap) begin
                            pc      <= trap_pc;
                            pc_prev <= pc;
                        end
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    boot_cnt <= BOOT_LAST;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule
